// File: rtl/key_event_arbiter.sv
// key_event_arbiter
// Collects single-cycle key events from four debouncers (short/long per key),
// arbitrates pending events round-robin and queues them in a small FIFO for
// a downstream consumer.
// Optional feature: define KEY_EVENT_OVF_EN to get a sticky lost-event flag
// on oOverflow; without it oOverflow is tied low and lost events are silent.

module key_event_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [7:0]    iTrig,
    input  logic          iAck,
    output logic          oValid,
    output logic [2:0]    oCode,
    output logic [CW-1:0] oCount,
    output logic          oOverflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    pending;
    logic [2:0]    lastGrant;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [2:0]    fifoMem [DEPTH];

    logic          fifoFull;
    logic          push;
    logic          pop;
    logic          grantValid;
    logic [2:0]    grantIdx;
    logic [2:0]    searchIdx;
    logic [7:0]    grantMask;
    logic [2:0]    grantCode;

    // Full is judged on the current count only; a same-cycle pop does not free a slot.
    assign fifoFull  = (count == CW'(DEPTH));
    assign push      = grantValid;
    assign pop       = oValid & iAck;
    // Index 2k is a long press (type 1), index 2k+1 a short click (type 0).
    assign grantCode = {grantIdx[2:1], ~grantIdx[0]};

    // Round-robin search starting just after the last granted index, wrapping through all eight.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = lastGrant;
        searchIdx  = lastGrant;
        if (!fifoFull) begin
            for (int k = 1; k <= 8; k++) begin
                searchIdx = lastGrant + 3'(k);
                if (!grantValid && pending[searchIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = searchIdx;
                end
            end
        end
    end

    // One-hot mask of the bit being granted this cycle.
    always_comb begin
        grantMask = '0;
        if (grantValid) begin
            grantMask[grantIdx] = 1'b1;
        end
    end

    // Pending bits, arbiter pointer and FIFO bookkeeping.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pending   <= '0;
            lastGrant <= 3'd7;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
        end else begin
            pending <= (pending & ~grantMask) | iTrig;
            if (grantValid) begin
                lastGrant <= grantIdx;
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because oValid gates the head.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            fifoMem[wrPtr] <= grantCode;
        end
    end

    assign oValid = (count != '0);
    assign oCode  = oValid ? fifoMem[rdPtr] : 3'b000;
    assign oCount = count;

`ifdef KEY_EVENT_OVF_EN
    logic overflowFlag;
    logic lostEvent;

    // A pulse on a bit that is still pending and not being granted is lost.
    assign lostEvent = |(iTrig & pending & ~grantMask);

    // Sticky lost-event flag, cleared only by reset.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            overflowFlag <= 1'b0;
        end else if (lostEvent) begin
            overflowFlag <= 1'b1;
        end
    end

    assign oOverflow = overflowFlag;
`else
    assign oOverflow = 1'b0;
`endif

endmodule
